// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and enums for the unified memory port arbiter
// Contents: ADDR_W/D_SIZE defaults, counter width for the fetch starvation count,
//           rd_owner_t (which port owns the read data returning next cycle),
//           arb_state_t (halt drain sequencing).
package mem_port_arbiter_pkg;

  localparam int ADDR_W   = 10;
  localparam int D_SIZE   = 32;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    DM   = 2'd2
  } rd_owner_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// rtl/mem_port_arbiter_sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst_n (async active-low), inc (count up, stops at MAX),
//        clr (synchronous clear, wins over inc), cnt (current count).
module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the single unified memory
// Ports: clk, reset (async active-low);
//        fetch port  if_req/if_addr -> if_gnt, if_rvalid/if_rdata;
//        data port   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt, dm_rvalid/dm_rdata;
//        memory      mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in (1-cycle registered);
//        control     halt in, halted out, stall_cycles out.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = mem_port_arbiter_pkg::ADDR_W,
  parameter int D_SIZE     = mem_port_arbiter_pkg::D_SIZE,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [D_SIZE-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [D_SIZE-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [D_SIZE-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [D_SIZE-1:0] mem_wdata,
  input  logic [D_SIZE-1:0] mem_rdata,
  input  logic              halt,
  output logic              halted,
  output logic [31:0]       stall_cycles
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q;
  logic                halted_q;
  rd_owner_t           rd_owner_q, rd_owner_d;
  logic [D_SIZE-1:0]   if_rdata_q, dm_rdata_q;
  logic [STARVE_W-1:0] starve_cnt;
  logic                if_win, dm_win;
  logic                if_denied, dm_denied;

  // Data wins a tie unless fetch has been denied STARVE_MAX cycles in a row.
  // Fetch is only eligible in RUN; data is served until HALTED.
  assign if_win = (state_q == RUN) && if_req && (!dm_req || (starve_cnt == STARVE_MAX_C));
  assign dm_win = (state_q != HALTED) && dm_req && !if_win;

  assign if_denied = if_req && !if_win;
  assign dm_denied = dm_req && !dm_win;

  // Reset masks only the outputs; the internal state is held in reset anyway,
  // so keeping reset out of the flop data paths costs nothing.
  assign if_gnt    = if_win && reset;
  assign dm_gnt    = dm_win && reset;
  assign mem_en    = if_gnt || dm_gnt;
  assign mem_we    = dm_gnt && dm_we;
  assign mem_addr  = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
  assign mem_wdata = mem_we ? dm_wdata : '0;

  always_comb begin
    rd_owner_d = NONE;
    if (if_win) begin
      rd_owner_d = IF;
    end else if (dm_win && !dm_we) begin
      rd_owner_d = DM;
    end
  end

  // The owning port sees mem_rdata live; the other port replays its last word.
  assign if_rvalid = (rd_owner_q == IF);
  assign dm_rvalid = (rd_owner_q == DM);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= NONE;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (rd_owner_q == IF) begin
        if_rdata_q <= mem_rdata;
      end
      if (rd_owner_q == DM) begin
        dm_rdata_q <= mem_rdata;
      end
    end
  end

  // Halt sequencing: a halt deassertion during DRAIN is deliberately ignored,
  // and HALTED only leaves through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if ((rd_owner_q == NONE) && !dm_req) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign halted = halted_q;

  sat_counter #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_MAX_C)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (if_denied),
    .clr   (!if_denied),
    .cnt   (starve_cnt)
  );

  sat_counter #(
    .WIDTH (32),
    .MAX   (32'hFFFF_FFFF)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   ((if_denied || dm_denied) && (state_q != HALTED)),
    .clr   (1'b0),
    .cnt   (stall_cycles)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int D_SIZE     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [D_SIZE-1:0] if_rdata;
  logic              dm_req = 1'b0, dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [D_SIZE-1:0] dm_wdata = '0;
  logic              dm_gnt, dm_rvalid;
  logic [D_SIZE-1:0] dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [D_SIZE-1:0] mem_wdata;
  logic [D_SIZE-1:0] mem_rdata;
  logic              halt = 1'b0;
  logic              halted;
  logic [31:0]       stall_cycles;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .D_SIZE(D_SIZE), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .halt(halt), .halted(halted), .stall_cycles(stall_cycles)
  );

  function automatic logic [31:0] preload(int i);
    return (i == 5) ? 32'h0000_1234 : (32'hA000_0000 | 32'(i));
  endfunction

  // Synchronous memory seen by the arbiter: registered read, one cycle latency.
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = preload(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 running, 1 draining, 2 halted. pend: 0 nothing, 1 fetch, 2 data
  logic [31:0] ref_mem [1024];
  int          m_phase, m_starve, m_pend;
  int unsigned m_stall;
  logic [31:0] m_pend_data, m_if_hold, m_dm_hold;
  logic        e_if_gnt, e_dm_gnt, e_if_rvalid, e_dm_rvalid, e_halted;
  logic [31:0] e_if_rdata, e_dm_rdata, e_stall;

  task automatic model_reset();
    m_phase = 0; m_starve = 0; m_pend = 0; m_stall = 0;
    m_pend_data = '0; m_if_hold = '0; m_dm_hold = '0;
  endtask

  task automatic model_eval();
    e_if_gnt    = (m_phase == 0) && if_req && (!dm_req || (m_starve == STARVE_MAX));
    e_dm_gnt    = (m_phase != 2) && dm_req && !e_if_gnt;
    e_if_rvalid = (m_pend == 1);
    e_dm_rvalid = (m_pend == 2);
    e_if_rdata  = (m_pend == 1) ? m_pend_data : m_if_hold;
    e_dm_rdata  = (m_pend == 2) ? m_pend_data : m_dm_hold;
    e_halted    = (m_phase == 2);
    e_stall     = m_stall;
  endtask

  task automatic model_commit();
    bit if_den, dm_den;
    if (m_pend == 1) m_if_hold = m_pend_data;
    if (m_pend == 2) m_dm_hold = m_pend_data;
    if_den = if_req && !e_if_gnt;
    dm_den = dm_req && !e_dm_gnt;
    if (m_phase != 2 && (if_den || dm_den) && m_stall != 32'hFFFF_FFFF) m_stall++;
    m_starve = if_den ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
    if (m_phase == 0 && halt) m_phase = 1;
    else if (m_phase == 1 && m_pend == 0 && !dm_req) m_phase = 2;
    m_pend = 0;
    if (e_if_gnt) begin
      m_pend = 1; m_pend_data = ref_mem[if_addr];
    end else if (e_dm_gnt && !dm_we) begin
      m_pend = 2; m_pend_data = ref_mem[dm_addr];
    end else if (e_dm_gnt && dm_we) begin
      ref_mem[dm_addr] = dm_wdata;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic ir, input logic [9:0] ia, input logic dr, input logic dw,
                       input logic [9:0] da, input logic [31:0] dd, input logic h);
    @(negedge clk);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd; halt = h;
    model_eval();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_cycles, 0);
    @(negedge clk);
    if_req = 0; dm_req = 0; dm_we = 0; halt = 0;
    reset = 1'b1;
  endtask

  typedef struct {
    logic ir; logic [9:0] ia; logic dr; logic dw; logic [9:0] da; logic [31:0] dd; logic h;
    logic e_ig; logic e_dg; logic e_irv; logic [31:0] e_ird;
    logic e_drv; logic [31:0] e_drd; logic [31:0] e_st;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // fetch only, contention for 6 cycles, write then read-back
    tbl[0]  = '{1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'd0};
    tbl[1]  = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 32'h0,        32'd0};
    tbl[2]  = '{1'b1, 10'd9, 1'b1, 1'b0, 10'd3, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 32'h0,        32'd0};
    tbl[3]  = '{1'b1, 10'd9, 1'b1, 1'b0, 10'd4, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'hA000_0003, 32'd1};
    tbl[4]  = '{1'b1, 10'd9, 1'b1, 1'b0, 10'd5, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'hA000_0004, 32'd2};
    tbl[5]  = '{1'b1, 10'd9, 1'b1, 1'b0, 10'd6, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_1234, 32'd3};
    tbl[6]  = '{1'b1, 10'd9, 1'b1, 1'b0, 10'd8, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 1'b1, 32'hA000_0006, 32'd4};
    tbl[7]  = '{1'b1, 10'd9, 1'b1, 1'b0, 10'd8, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0009, 1'b0, 32'hA000_0006, 32'd5};
    tbl[8]  = '{1'b0, 10'd0, 1'b1, 1'b1, 10'd7, 32'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0009, 1'b1, 32'hA000_0008, 32'd6};
    tbl[9]  = '{1'b0, 10'd0, 1'b1, 1'b0, 10'd7, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0009, 1'b0, 32'hA000_0008, 32'd6};
    tbl[10] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'hA000_0009, 1'b1, 32'h0000_DEAD, 32'd6};
    tbl[11] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'hA000_0009, 1'b0, 32'h0000_DEAD, 32'd6};

    for (int i = 0; i < 1024; i++) ref_mem[i] = preload(i);
    model_reset();

    // reset with requests driven
    reset = 1'b0; if_req = 1; dm_req = 1; dm_we = 1; if_addr = 10'd3; dm_addr = 10'd4; dm_wdata = 32'h55;
    #12;
    chk("init_if_gnt", if_gnt, 0);
    chk("init_dm_gnt", dm_gnt, 0);
    chk("init_mem_en", mem_en, 0);
    chk("init_mem_we", mem_we, 0);
    chk("init_mem_addr", 32'(mem_addr), 0);
    chk("init_mem_wdata", mem_wdata, 0);
    chk("init_if_rvalid", if_rvalid, 0);
    chk("init_dm_rvalid", dm_rvalid, 0);
    chk("init_if_rdata", if_rdata, 0);
    chk("init_dm_rdata", dm_rdata, 0);
    chk("init_halted", halted, 0);
    chk("init_stall", stall_cycles, 0);
    @(negedge clk);
    if_req = 0; dm_req = 0; dm_we = 0;
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, tbl[i].h);
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_ig);
      chk($sformatf("tbl%0d_dm_gnt", i), dm_gnt, tbl[i].e_dg);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].e_ig | tbl[i].e_dg);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_dg & tbl[i].dw);
      chk($sformatf("tbl%0d_if_rvalid", i), if_rvalid, tbl[i].e_irv);
      chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].e_ird);
      chk($sformatf("tbl%0d_dm_rvalid", i), dm_rvalid, tbl[i].e_drv);
      chk($sformatf("tbl%0d_dm_rdata", i), dm_rdata, tbl[i].e_drd);
      chk($sformatf("tbl%0d_stall", i), stall_cycles, tbl[i].e_st);
      chk($sformatf("tbl%0d_halted", i), halted, 0);
      tick();
    end

    // halt drain with a data read in flight and fetch held
    drive(1, 10'd21, 1, 0, 10'd20, 0, 1);
    chk("h0_if_gnt", if_gnt, 0); chk("h0_dm_gnt", dm_gnt, 1); chk("h0_stall", stall_cycles, 6);
    tick();
    drive(1, 10'd21, 0, 0, 10'd0, 0, 0);
    chk("h1_if_gnt", if_gnt, 0); chk("h1_dm_rvalid", dm_rvalid, 1);
    chk("h1_dm_rdata", dm_rdata, 32'hA000_0014); chk("h1_halted", halted, 0); chk("h1_stall", stall_cycles, 7);
    tick();
    drive(1, 10'd21, 0, 0, 10'd0, 0, 0);
    chk("h2_if_gnt", if_gnt, 0); chk("h2_dm_rvalid", dm_rvalid, 0);
    chk("h2_halted", halted, 0); chk("h2_stall", stall_cycles, 8);
    tick();
    for (int k = 3; k < 5; k++) begin
      drive(1, 10'd21, 1, 0, 10'd22, 0, 0);
      chk($sformatf("h%0d_if_gnt", k), if_gnt, 0); chk($sformatf("h%0d_dm_gnt", k), dm_gnt, 0);
      chk($sformatf("h%0d_mem_en", k), mem_en, 0); chk($sformatf("h%0d_halted", k), halted, 1);
      chk($sformatf("h%0d_stall", k), stall_cycles, 9);
      tick();
    end

    // leave HALTED, build starvation, then reset the cycle after a read grant
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 10'd40, 1, 0, 10'(30 + k), 0, 0);
      chk($sformatf("m%0d_dm_gnt", k), dm_gnt, 1);
      tick();
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_dm_rvalid", dm_rvalid, 0); chk("mid_if_rvalid", if_rvalid, 0);
    chk("mid_dm_gnt", dm_gnt, 0); chk("mid_stall", stall_cycles, 0);
    @(negedge clk);
    if_req = 0; dm_req = 0; reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 10'd41, 1, 0, 10'(50 + k), 0, 0);
      chk($sformatf("p%0d_dm_gnt", k), dm_gnt, (k < 4) ? 1 : 0);
      chk($sformatf("p%0d_if_gnt", k), if_gnt, (k < 4) ? 0 : 1);
      if (k == 0) begin
        chk("p0_dm_rvalid", dm_rvalid, 0); chk("p0_stall", stall_cycles, 0); chk("p0_halted", halted, 0);
      end
      tick();
    end

    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if (($urandom_range(0, 199) == 0) || (m_phase == 2 && $urandom_range(0, 9) == 0)) begin
        apply_reset();
      end else begin
        drive($urandom_range(0, 9) < 7, 10'($urandom_range(0, 15)),
              $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
              10'($urandom_range(0, 15)), $urandom, $urandom_range(0, 149) == 0);
        chk("rnd_if_gnt", if_gnt, e_if_gnt);
        chk("rnd_dm_gnt", dm_gnt, e_dm_gnt);
        chk("rnd_mem_en", mem_en, e_if_gnt | e_dm_gnt);
        if (e_if_gnt) chk("rnd_mem_addr_if", 32'(mem_addr), 32'(if_addr));
        if (e_dm_gnt) chk("rnd_mem_addr_dm", 32'(mem_addr), 32'(dm_addr));
        chk("rnd_mem_we", mem_we, e_dm_gnt & dm_we);
        if (e_dm_gnt && dm_we) chk("rnd_mem_wdata", mem_wdata, dm_wdata);
        chk("rnd_if_rvalid", if_rvalid, e_if_rvalid);
        chk("rnd_if_rdata", if_rdata, e_if_rdata);
        chk("rnd_dm_rvalid", dm_rvalid, e_dm_rvalid);
        chk("rnd_dm_rdata", dm_rdata, e_dm_rdata);
        chk("rnd_halted", halted, e_halted);
        chk("rnd_stall", stall_cycles, e_stall);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
